// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and latency constants for the mul/div sequencer.
// Option MULTDIV_REMAINDER_EN adds the DIV_FIX_R state and one divide cycle.
package multdiv_pkg;

  localparam int W          = 32;
  localparam int ITER_COUNT = 32;
  localparam int MUL_LATENCY  = 33;
  localparam int DIV0_LATENCY = 1;
`ifdef MULTDIV_REMAINDER_EN
  localparam int DIV_LATENCY = 37;
`else
  localparam int DIV_LATENCY = 36;
`endif

  typedef enum logic [2:0] {
    IDLE,
    MUL_ITER,
    DIV_ABS_A,
    DIV_ABS_B,
    DIV_ITER,
    DIV_FIX,
`ifdef MULTDIV_REMAINDER_EN
    DIV_FIX_R,
`endif
    DONE
  } state_t;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_t;

endpackage

// File: rtl/multdiv_seq_ctrl_if.sv
// multdiv_seq_ctrl_if: start/operand/result handshake plus shared-adder bus.
// slave = sequencer side, master = pipeline/adder side; MULTDIV_REMAINDER_EN adds data_remainder.
interface multdiv_seq_ctrl_if;
  import multdiv_pkg::*;

  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
`ifdef MULTDIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_ovf;

`ifdef MULTDIV_REMAINDER_EN
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  add_sum, add_ovf,
    output data_result, data_exception, data_resultRDY,
    output data_remainder,
    output add_a, add_b, add_cin
  );
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output add_sum, add_ovf,
    input  data_result, data_exception, data_resultRDY,
    input  data_remainder,
    input  add_a, add_b, add_cin
  );
`else
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  add_sum, add_ovf,
    output data_result, data_exception, data_resultRDY,
    output add_a, add_b, add_cin
  );
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output add_sum, add_ovf,
    input  data_result, data_exception, data_resultRDY,
    input  add_a, add_b, add_cin
  );
`endif

endinterface

// File: rtl/multdiv_iter_cnt.sv
// multdiv_iter_cnt: 6-bit load/decrement iteration counter.
// Ports: clock, reset (sync, active-high), load_i, dec_i, done_o (last iteration).
module multdiv_iter_cnt
  import multdiv_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = 6'(ITER_COUNT);
    else if (dec_i) cnt_d = cnt_q - 6'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 6'd1);

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// multdiv_seq_ctrl: Booth multiply / restoring divide sequencer using one external adder per cycle.
// Ports: clock, reset (sync, active-high), bus (slave): start pulses, operands, result/exc/RDY, adder.
// Option MULTDIV_REMAINDER_EN: data_remainder output and a remainder sign-fix cycle.
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  multdiv_seq_ctrl_if.slave bus
);

  typedef logic [WIDTH-1:0] word_t;

  state_t state_q, state_d;
  word_t  acc_q, acc_d;
  word_t  lo_q, lo_d;
  word_t  m_q, m_d;
  logic   q_q, q_d;
  logic   a_sgn_q, a_sgn_d;
  logic   b_sgn_q, b_sgn_d;
  word_t  res_q, res_d;
  logic   exc_q, exc_d;
  logic   rdy_q, rdy_d;
`ifdef MULTDIV_REMAINDER_EN
  word_t  rem_q, rem_d;
`endif

  word_t  add_a, add_b, r_sh;
  logic   add_cin;
  logic   cnt_load, cnt_dec, cnt_done;
  logic   start, msb, carry, neg;
  op_t    op;

  multdiv_iter_cnt u_cnt (
    .clock  (clock),
    .reset  (reset),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .done_o (cnt_done)
  );

  assign start = (state_q == IDLE || state_q == DONE) &&
                 (bus.ctrl_MULT || bus.ctrl_DIV);
  assign op    = bus.ctrl_MULT ? OP_MUL : OP_DIV;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    m_d      = m_q;
    q_d      = q_q;
    a_sgn_d  = a_sgn_q;
    b_sgn_d  = b_sgn_q;
    res_d    = res_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
    rem_d    = rem_q;
`endif
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    msb      = 1'b0;
    carry    = 1'b0;
    neg      = a_sgn_q ^ b_sgn_q;
    r_sh     = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          res_d = '0;
          exc_d = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
          rem_d = '0;
`endif
          if (op == OP_MUL) begin
            acc_d    = '0;
            lo_d     = bus.data_operandB;
            q_d      = 1'b0;
            m_d      = bus.data_operandA;
            cnt_load = 1'b1;
            state_d  = MUL_ITER;
          end else if (bus.data_operandB == '0) begin
            exc_d   = 1'b1;
            rdy_d   = 1'b1;
`ifdef MULTDIV_REMAINDER_EN
            rem_d   = bus.data_operandA;
`endif
            state_d = DONE;
          end else begin
            acc_d   = '0;
            lo_d    = bus.data_operandA;
            m_d     = bus.data_operandB;
            a_sgn_d = bus.data_operandA[WIDTH-1];
            b_sgn_d = bus.data_operandB[WIDTH-1];
            state_d = DIV_ABS_A;
          end
        end
      end
      MUL_ITER: begin
        add_a = acc_q;
        case ({lo_q[0], q_q})
          2'b01:   add_b = m_q;
          2'b10: begin
            add_b   = ~m_q;
            add_cin = 1'b1;
          end
          default: add_b = '0;
        endcase
        // overflow-corrected sign keeps the shift exact when hi-M wraps
        msb     = bus.add_sum[WIDTH-1] ^ bus.add_ovf;
        acc_d   = {msb, bus.add_sum[WIDTH-1:1]};
        lo_d    = {bus.add_sum[0], lo_q[WIDTH-1:1]};
        q_d     = lo_q[0];
        cnt_dec = 1'b1;
        if (cnt_done) begin
          res_d   = lo_d;
          exc_d   = (acc_d != {WIDTH{lo_d[WIDTH-1]}});
          rdy_d   = 1'b1;
          state_d = DONE;
        end
      end
      DIV_ABS_A: begin
        add_b   = ~lo_q;
        add_cin = 1'b1;
        if (a_sgn_q) lo_d = bus.add_sum;
        state_d = DIV_ABS_B;
      end
      DIV_ABS_B: begin
        add_b    = ~m_q;
        add_cin  = 1'b1;
        if (b_sgn_q) m_d = bus.add_sum;
        cnt_load = 1'b1;
        state_d  = DIV_ITER;
      end
      DIV_ITER: begin
        add_a   = r_sh;
        add_b   = ~m_q;
        add_cin = 1'b1;
        // carry out of bit 31 means r_sh >= |B|
        carry   = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                  ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~bus.add_sum[WIDTH-1]);
        acc_d   = carry ? bus.add_sum : r_sh;
        lo_d    = {lo_q[WIDTH-2:0], carry};
        cnt_dec = 1'b1;
        if (cnt_done) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        if (neg) begin
          add_b   = ~lo_q;
          add_cin = 1'b1;
        end else begin
          add_a   = lo_q;
        end
        if (!neg && lo_q == {1'b1, {(WIDTH-1){1'b0}}}) begin
          res_d = '0;
          exc_d = 1'b1;
        end else begin
          res_d = bus.add_sum;
        end
`ifdef MULTDIV_REMAINDER_EN
        state_d = DIV_FIX_R;
`else
        rdy_d   = 1'b1;
        state_d = DONE;
`endif
      end
`ifdef MULTDIV_REMAINDER_EN
      DIV_FIX_R: begin
        if (a_sgn_q) begin
          add_b   = ~acc_q;
          add_cin = 1'b1;
        end else begin
          add_a   = acc_q;
        end
        rem_d   = bus.add_sum;
        rdy_d   = 1'b1;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      q_q     <= 1'b0;
      a_sgn_q <= 1'b0;
      b_sgn_q <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_sgn_q <= a_sgn_d;
      b_sgn_q <= b_sgn_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
`ifdef MULTDIV_REMAINDER_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign bus.add_a          = add_a;
  assign bus.add_b          = add_b;
  assign bus.add_cin        = add_cin;
  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
`ifdef MULTDIV_REMAINDER_EN
  assign bus.data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// tb_multdiv_seq_ctrl: directed + random checks of the mul/div sequencer
// against a plain-arithmetic reference model, with a behavioural shared adder.
module tb_multdiv_seq_ctrl;
  import multdiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  multdiv_seq_ctrl_if bus ();

  assign bus.add_sum = bus.add_a + bus.add_b + {31'b0, bus.add_cin};
  assign bus.add_ovf = (bus.add_a[31] == bus.add_b[31]) &&
                       (bus.add_sum[31] != bus.add_a[31]);

  multdiv_seq_ctrl #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic void model(input bit mul, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic e, output int lat);
    longint p;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (mul) begin
      p   = longint'(sa) * longint'(sb);
      r   = p[31:0];
      e   = (p != longint'(int'(p[31:0])));
      lat = MUL_LATENCY;
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1; lat = DIV0_LATENCY;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'd0; e = 1'b1; lat = DIV_LATENCY;
    end else begin
      r = 32'(sa / sb); e = 1'b0; lat = DIV_LATENCY;
    end
  endfunction

`ifdef MULTDIV_REMAINDER_EN
  function automatic logic [31:0] model_rem(input bit mul, input logic [31:0] a,
                                            input logic [31:0] b);
    if (mul) return 32'd0;
    if (b == 32'd0) return a;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
    return 32'(int'(a) % int'(b));
  endfunction
`endif

  task automatic do_op(input string tag, input bit m, input bit d,
                       input logic [31:0] a, input logic [31:0] b,
                       input int glitch);
    logic [31:0] er, res_seen;
    logic ee;
    int el, cyc;
    model(m, a, b, er, ee, el);
    @(negedge clk);
    bus.ctrl_MULT = m;
    bus.ctrl_DIV  = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    cyc = 1;
    if (el > 1) check({tag, ":clr"}, bus.data_result, 32'd0);
    while (!bus.data_resultRDY && cyc < 64) begin
      bus.ctrl_MULT = (glitch != 0 && cyc == glitch);
      @(negedge clk);
      cyc++;
    end
    bus.ctrl_MULT = 1'b0;
    check({tag, ":lat"}, 32'(cyc), 32'(el));
    check({tag, ":res"}, bus.data_result, er);
    check({tag, ":exc"}, {31'b0, bus.data_exception}, {31'b0, ee});
`ifdef MULTDIV_REMAINDER_EN
    check({tag, ":rem"}, bus.data_remainder, model_rem(m, a, b));
`endif
    res_seen = bus.data_result;
    @(negedge clk);
    check({tag, ":rdy_low"}, {31'b0, bus.data_resultRDY}, 32'd0);
    check({tag, ":hold"}, bus.data_result, er);
  endtask

  initial begin
    int rdy_cnt;
    bit rm;
    logic [31:0] ra, rb;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:res", bus.data_result, 32'd0);
    check("rst:exc", {31'b0, bus.data_exception}, 32'd0);
    check("rst:rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    check("rst:add_a", bus.add_a, 32'd0);
    check("rst:add_b", bus.add_b, 32'd0);
    check("rst:cin", {31'b0, bus.add_cin}, 32'd0);
`ifdef MULTDIV_REMAINDER_EN
    check("rst:rem", bus.data_remainder, 32'd0);
`endif
    rst = 1'b0;

    do_op("mul_7_m3",    1, 0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op("mul_ovf",     1, 0, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("mul_min_1",   1, 0, 32'h8000_0000, 32'd1, 0);
    do_op("div_m17_5",   0, 1, 32'hFFFF_FFEF, 32'd5, 0);
    do_op("div_by0",     0, 1, 32'd100, 32'd0, 0);
    do_op("div_min_m1",  0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("div_glitch",  0, 1, 32'hFFFF_FFEF, 32'd5, 10);

    @(negedge clk);
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'd1234;
    bus.data_operandB = 32'd5678;
    @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rrst:res", bus.data_result, 32'd0);
    check("rrst:exc", {31'b0, bus.data_exception}, 32'd0);
    check("rrst:rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    check("rrst:add_a", bus.add_a, 32'd0);
    check("rrst:add_b", bus.add_b, 32'd0);
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.data_resultRDY) rdy_cnt++;
    end
    check("rrst:no_rdy", 32'(rdy_cnt), 32'd0);

    do_op("both_hi", 1, 1, 32'd123456, 32'hFFFF_FCEB, 0);

    for (int i = 0; i < 16; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if (!rm && $urandom_range(0, 7) == 0) rb = 32'd0;
      do_op($sformatf("rnd%0d", i), rm, !rm, ra, rb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
